// File: rtl/trap_ctrl.sv
// trap_ctrl
//   Sequences machine-mode trap entry (ecall) and trap return (mret) through
//   the CSR file's single write port. Instruction CSR writes share that port
//   and are granted only while the controller is idle.
//
// Ports
//   clk_i, rst_ni                      clock, async active-low reset
//   ecall_req_i, mret_req_i            committed ecall / mret requests
//   trap_pc_i, trap_cause_i            trapping PC and mcause value
//   req_ready_o                        idle; a request is accepted this cycle
//   inst_csr_we_i/_waddr_i/_wdata_i    instruction CSR write request
//   inst_csr_ready_o                   instruction write granted this cycle
//   csr_we_o, csr_waddr_o, csr_wdata_o CSR file write port
//   csr_mstatus_i, csr_mtvec_i,
//   csr_mepc_i                         current CSR values
//   redirect_valid_o, redirect_pc_o    one-cycle PC redirect to the IFU
//   busy_o                             sequence in progress
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | accept ecall/mret; pass instruction CSR writes through
// T_EPC    | write MEPC with the captured, word-aligned PC
// T_CAUSE  | write MCAUSE with the captured cause
// T_STATUS | write trap-entry MSTATUS; latch MTVEC base as the target
// R_STATUS | write trap-return MSTATUS; latch MEPC as the target
// REDIR    | one-cycle redirect strobe, no CSR write

module trap_ctrl #(
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int CSR_DATA_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      ecall_req_i,
    input  logic                      mret_req_i,
    input  logic [CSR_DATA_WIDTH-1:0] trap_pc_i,
    input  logic [CSR_DATA_WIDTH-1:0] trap_cause_i,
    output logic                      req_ready_o,
    input  logic                      inst_csr_we_i,
    input  logic [CSR_ADDR_WIDTH-1:0] inst_csr_waddr_i,
    input  logic [CSR_DATA_WIDTH-1:0] inst_csr_wdata_i,
    output logic                      inst_csr_ready_o,
    output logic                      csr_we_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
    output logic [CSR_DATA_WIDTH-1:0] csr_wdata_o,
    input  logic [CSR_DATA_WIDTH-1:0] csr_mstatus_i,
    input  logic [CSR_DATA_WIDTH-1:0] csr_mtvec_i,
    input  logic [CSR_DATA_WIDTH-1:0] csr_mepc_i,
    output logic                      redirect_valid_o,
    output logic [CSR_DATA_WIDTH-1:0] redirect_pc_o,
    output logic                      busy_o
);

    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS = CSR_ADDR_WIDTH'(12'h300);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC    = CSR_ADDR_WIDTH'(12'h341);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE  = CSR_ADDR_WIDTH'(12'h342);
    localparam logic [CSR_DATA_WIDTH-1:0] ALIGN_MASK   = ~CSR_DATA_WIDTH'(3);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        T_EPC    = 3'd1,
        T_CAUSE  = 3'd2,
        T_STATUS = 3'd3,
        R_STATUS = 3'd4,
        REDIR    = 3'd5
    } state_t;

    state_t                    state_q, state_d;
    logic [CSR_DATA_WIDTH-1:0] pc_q, pc_d;
    logic [CSR_DATA_WIDTH-1:0] cause_q, cause_d;
    logic [CSR_DATA_WIDTH-1:0] target_q, target_d;
    logic [CSR_DATA_WIDTH-1:0] trap_status;
    logic [CSR_DATA_WIDTH-1:0] mret_status;

    // MSTATUS bit positions: MIE=3, MPIE=7, MPP=12:11
    always_comb begin
        trap_status        = csr_mstatus_i;
        trap_status[7]     = csr_mstatus_i[3];
        trap_status[3]     = 1'b0;
        trap_status[12:11] = 2'b11;

        mret_status        = csr_mstatus_i;
        mret_status[3]     = csr_mstatus_i[7];
        mret_status[7]     = 1'b1;
        mret_status[12:11] = 2'b11;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            cause_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cause_q  <= cause_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        cause_d          = cause_q;
        target_d         = target_q;
        req_ready_o      = 1'b0;
        inst_csr_ready_o = 1'b0;
        csr_we_o         = 1'b0;
        csr_waddr_o      = '0;
        csr_wdata_o      = '0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        busy_o           = 1'b1;

        case (state_q)
            IDLE: begin
                busy_o           = 1'b0;
                req_ready_o      = 1'b1;
                inst_csr_ready_o = 1'b1;
                // Gated by reset so the write port stays quiet while held in reset
                if (inst_csr_we_i && rst_ni) begin
                    csr_we_o    = 1'b1;
                    csr_waddr_o = inst_csr_waddr_i;
                    csr_wdata_o = inst_csr_wdata_i;
                end
                if (ecall_req_i) begin
                    pc_d    = trap_pc_i;
                    cause_d = trap_cause_i;
                    state_d = T_EPC;
                end else if (mret_req_i) begin
                    state_d = R_STATUS;
                end
            end
            T_EPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MEPC;
                csr_wdata_o = pc_q & ALIGN_MASK;
                state_d     = T_CAUSE;
            end
            T_CAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MCAUSE;
                csr_wdata_o = cause_q;
                state_d     = T_STATUS;
            end
            T_STATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = trap_status;
                // Direct mode only: the mode bits are simply dropped
                target_d    = csr_mtvec_i & ALIGN_MASK;
                state_d     = REDIR;
            end
            R_STATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = mret_status;
                target_d    = csr_mepc_i & ALIGN_MASK;
                state_d     = REDIR;
            end
            REDIR: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = target_q;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ecall_req_i, mret_req_i;
    logic [31:0] trap_pc_i, trap_cause_i;
    logic        req_ready_o;
    logic        inst_csr_we_i;
    logic [11:0] inst_csr_waddr_i;
    logic [31:0] inst_csr_wdata_i;
    logic        inst_csr_ready_o;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic [31:0] csr_mstatus_i, csr_mtvec_i, csr_mepc_i;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;

    trap_ctrl #(.CSR_ADDR_WIDTH(12), .CSR_DATA_WIDTH(32)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .ecall_req_i      (ecall_req_i),
        .mret_req_i       (mret_req_i),
        .trap_pc_i        (trap_pc_i),
        .trap_cause_i     (trap_cause_i),
        .req_ready_o      (req_ready_o),
        .inst_csr_we_i    (inst_csr_we_i),
        .inst_csr_waddr_i (inst_csr_waddr_i),
        .inst_csr_wdata_i (inst_csr_wdata_i),
        .inst_csr_ready_o (inst_csr_ready_o),
        .csr_we_o         (csr_we_o),
        .csr_waddr_o      (csr_waddr_o),
        .csr_wdata_o      (csr_wdata_o),
        .csr_mstatus_i    (csr_mstatus_i),
        .csr_mtvec_i      (csr_mtvec_i),
        .csr_mepc_i       (csr_mepc_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Simple CSR file that the controller writes into and reads from
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csr_mstatus_i <= 32'h0;
            csr_mtvec_i   <= 32'h0;
            csr_mepc_i    <= 32'h0;
        end else if (csr_we_o) begin
            case (csr_waddr_o)
                12'h300: csr_mstatus_i <= csr_wdata_o;
                12'h305: csr_mtvec_i   <= csr_wdata_o;
                12'h341: csr_mepc_i    <= csr_wdata_o;
                default: ;
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int          stamp;
        bit          is_redir;
        logic [11:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];

    // Reference model state
    logic [31:0] ref_mstatus, ref_mtvec, ref_mepc;
    int          busy_end = 0;
    bit          exp_idle = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        n_total++;
        $display("FAIL %s: got %h expected nothing (cycle %0d)", name, act, cyc);
    endtask

    function automatic logic [31:0] entry_status(input logic [31:0] m);
        logic mie = m[3];
        logic [31:0] r = m & ~32'h0000_1888;   // clear MPP, MPIE, MIE
        return r | 32'h0000_1800 | (mie ? 32'h80 : 32'h0);
    endfunction

    function automatic logic [31:0] return_status(input logic [31:0] m);
        logic mpie = m[7];
        logic [31:0] r = m & ~32'h0000_1888;
        return r | 32'h0000_1880 | (mpie ? 32'h8 : 32'h0);
    endfunction

    function automatic ev_t mk(input int s, input bit r, input logic [11:0] a, input logic [31:0] d);
        ev_t e;
        e.stamp = s; e.is_redir = r; e.addr = a; e.data = d;
        return e;
    endfunction

    // One requester cycle: drive inputs just after the edge, then let the
    // reference model decide what the controller must do with them.
    task automatic step(input bit we, input logic [11:0] wa, input logic [31:0] wd,
                        input bit ec, input bit mr, input logic [31:0] pc, input logic [31:0] cause);
        @(posedge clk_i);
        #1;
        inst_csr_we_i    = we;
        inst_csr_waddr_i = wa;
        inst_csr_wdata_i = wd;
        ecall_req_i      = ec;
        mret_req_i       = mr;
        trap_pc_i        = pc;
        trap_cause_i     = cause;
        exp_idle = (cyc >= busy_end);
        if (exp_idle) begin
            if (we) begin
                exp_q.push_back(mk(cyc, 1'b0, wa, wd));
                if (wa == 12'h300) ref_mstatus = wd;
                if (wa == 12'h305) ref_mtvec   = wd;
                if (wa == 12'h341) ref_mepc    = wd;
            end
            if (ec) begin
                exp_q.push_back(mk(cyc + 1, 1'b0, 12'h341, {pc[31:2], 2'b00}));
                exp_q.push_back(mk(cyc + 2, 1'b0, 12'h342, cause));
                ref_mstatus = entry_status(ref_mstatus);
                exp_q.push_back(mk(cyc + 3, 1'b0, 12'h300, ref_mstatus));
                ref_mepc = {pc[31:2], 2'b00};
                exp_q.push_back(mk(cyc + 4, 1'b1, 12'h0, {ref_mtvec[31:2], 2'b00}));
                busy_end = cyc + 5;
            end else if (mr) begin
                ref_mstatus = return_status(ref_mstatus);
                exp_q.push_back(mk(cyc + 1, 1'b0, 12'h300, ref_mstatus));
                exp_q.push_back(mk(cyc + 2, 1'b1, 12'h0, {ref_mepc[31:2], 2'b00}));
                busy_end = cyc + 3;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 12'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic hold_write(input logic [11:0] wa, input logic [31:0] wd);
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step(1, wa, wd, 0, 0, 32'h0, 32'h0);
            done = exp_idle;
        end
        if (!done) fail("held_write_never_granted", 64'h0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        ref_mstatus = 32'h0;
        ref_mtvec   = 32'h0;
        ref_mepc    = 32'h0;
        busy_end    = 0;
        exp_idle    = 1'b1;
    endtask

    task automatic zero_inputs();
        inst_csr_we_i = 0; inst_csr_waddr_i = 0; inst_csr_wdata_i = 0;
        ecall_req_i = 0; mret_req_i = 0; trap_pc_i = 0; trap_cause_i = 0;
    endtask

    task automatic mid_reset();
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        zero_inputs();
        model_reset();
        #1;
        chk("async_reset_outputs", {busy_o, csr_we_o, redirect_valid_o, redirect_pc_o}, 64'h0);
        repeat (2) @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            chk("reset_outputs", {busy_o, csr_we_o, redirect_valid_o, redirect_pc_o}, 64'h0);
        end else begin
            while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
                fail("missed_event", {exp_q[0].addr, exp_q[0].data});
                void'(exp_q.pop_front());
            end
            chk("ready_busy", {req_ready_o, inst_csr_ready_o, busy_o},
                {exp_idle, exp_idle, ~exp_idle});
            if (csr_we_o) begin
                if (exp_q.size() == 0 || exp_q[0].is_redir || exp_q[0].stamp != cyc) begin
                    fail("unexpected_csr_write", {csr_waddr_o, csr_wdata_o});
                end else begin
                    chk("csr_waddr", csr_waddr_o, exp_q[0].addr);
                    chk("csr_wdata", csr_wdata_o, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end else begin
                chk("quiet_write_port", {csr_waddr_o, csr_wdata_o}, 64'h0);
            end
            if (redirect_valid_o) begin
                if (exp_q.size() == 0 || !exp_q[0].is_redir || exp_q[0].stamp != cyc) begin
                    fail("unexpected_redirect", redirect_pc_o);
                end else begin
                    chk("redirect_pc", redirect_pc_o, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end else begin
                chk("quiet_redirect_pc", redirect_pc_o, 64'h0);
            end
        end
    end

    logic [11:0] addrs [5];

    initial begin
        rst_ni = 1'b1;
        zero_inputs();
        model_reset();
        #1 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #3 rst_ni = 1'b1;

        // ecall: MEPC/MCAUSE/MSTATUS then redirect to the MTVEC base
        step(1, 12'h300, 32'h0000_0008, 0, 0, 32'h0, 32'h0);
        step(1, 12'h305, 32'h8000_0201, 0, 0, 32'h0, 32'h0);
        step(0, 12'h0, 32'h0, 1, 0, 32'h8000_0104, 32'd11);
        idle(5);

        // mret
        step(1, 12'h300, 32'h0000_1880, 0, 0, 32'h0, 32'h0);
        step(1, 12'h341, 32'h8000_0108, 0, 0, 32'h0, 32'h0);
        step(0, 12'h0, 32'h0, 0, 1, 32'h0, 32'h0);
        idle(3);

        // ecall and mret together: ecall only
        step(0, 12'h0, 32'h0, 1, 1, 32'h8000_0402, 32'd11);
        idle(6);

        // instruction write to MTVEC alongside ecall acceptance
        step(1, 12'h305, 32'h8000_0300, 1, 0, 32'h8000_050c, 32'd11);
        idle(6);

        // instruction write held from T_CAUSE until idle
        step(0, 12'h0, 32'h0, 1, 0, 32'h8000_0600, 32'd11);
        idle(1);
        hold_write(12'h305, 32'h8000_0700);
        idle(2);

        // reset during T_CAUSE
        step(0, 12'h0, 32'h0, 1, 0, 32'h8000_0800, 32'd11);
        idle(1);
        mid_reset();
        idle(6);

        // randomized traffic, including requests made while busy
        addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341;
        addrs[3] = 12'h342; addrs[4] = 12'h7c0;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3) == 0, addrs[$urandom_range(4)], $urandom,
                 $urandom_range(5) == 0, $urandom_range(5) == 0, $urandom, $urandom);
        end
        idle(8);
        chk("scoreboard_drained", exp_q.size(), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter CSR_ADDR_WIDTH, 12, CSR address width.
REQ-002 SHALL have parameter CSR_DATA_WIDTH, 32, CSR data and PC width.
REQ-003 SHALL have port clk_i  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ecall_req_i  in  1  committed ecall; sampled only when req_ready_o=1.
REQ-006 SHALL have port mret_req_i  in  1  committed mret; sampled only when req_ready_o=1.
REQ-007 SHALL have port trap_pc_i  in  CSR_DATA_WIDTH  PC of the trapping instruction.
REQ-008 SHALL have port trap_cause_i  in  CSR_DATA_WIDTH  mcause value (11 for M-mode ecall).
REQ-009 SHALL have port req_ready_o  out  1  controller idle; trap/mret request accepted this cycle.
REQ-010 SHALL have port inst_csr_we_i  in  1  instruction CSR write request (csrrw/csrrs/...).
REQ-011 SHALL have port inst_csr_waddr_i  in  CSR_ADDR_WIDTH  instruction write address.
REQ-012 SHALL have port inst_csr_wdata_i  in  CSR_DATA_WIDTH  instruction write data.
REQ-013 SHALL have port inst_csr_ready_o  out  1  instruction write granted this cycle.
REQ-014 SHALL have port csr_we_o  out  1  write enable to the CSR file's single write port.
REQ-015 SHALL have port csr_waddr_o  out  CSR_ADDR_WIDTH  write address to the CSR file.
REQ-016 SHALL have port csr_wdata_o  out  CSR_DATA_WIDTH  write data to the CSR file.
REQ-017 SHALL have port csr_mstatus_i  in  CSR_DATA_WIDTH  current MSTATUS from the CSR file.
REQ-018 SHALL have port csr_mtvec_i  in  CSR_DATA_WIDTH  current MTVEC.
REQ-019 SHALL have port csr_mepc_i  in  CSR_DATA_WIDTH  current MEPC.
REQ-020 SHALL have port redirect_valid_o  out  1  one-cycle PC redirect strobe to the IFU.
REQ-021 SHALL have port redirect_pc_o  out  CSR_DATA_WIDTH  redirect target, valid with the strobe.
REQ-022 SHALL have port busy_o  out  1  high in every state other than IDLE.

Function
REQ-023 SHALL use the CSR addresses MSTATUS=0x300, MTVEC=0x305, MEPC=0x341, MCAUSE=0x342.
REQ-024 SHALL implement the FSM states IDLE, T_EPC, T_CAUSE, T_STATUS, R_STATUS, REDIR.
REQ-025 SHALL assert req_ready_o and inst_csr_ready_o only in IDLE.
REQ-026 SHALL, in IDLE, drive csr_we_o/waddr_o/wdata_o combinationally from the inst_csr_* inputs, so a granted instruction write lands on the same edge as request acceptance.
REQ-027 SHALL, in IDLE with ecall_req_i=1, capture trap_pc_i and trap_cause_i and go to T_EPC; ecall wins when ecall_req_i and mret_req_i are both 1.
REQ-028 SHALL, in IDLE with only mret_req_i=1, go to R_STATUS.
REQ-029 SHALL write, in T_EPC, MEPC = captured pc with bits [1:0] cleared, then go to T_CAUSE.
REQ-030 SHALL write, in T_CAUSE, MCAUSE = captured cause, then go to T_STATUS.
REQ-031 SHALL write, in T_STATUS, csr_mstatus_i with MPIE(7)=MIE(3), MIE=0, MPP(12:11)=2'b11, all other bits unchanged, then go to REDIR with target csr_mtvec_i with bits [1:0] cleared (direct mode only).
REQ-032 SHALL write, in R_STATUS, csr_mstatus_i with MIE=MPIE, MPIE=1, MPP=2'b11, all other bits unchanged, then go to REDIR with target csr_mepc_i with bits [1:0] cleared.
REQ-033 SHALL, in REDIR, assert redirect_valid_o for exactly one cycle with csr_we_o=0, then return to IDLE.
REQ-034 SHALL give a fixed latency: ecall accept edge to redirect strobe = 4 cycles; mret = 2 cycles.
REQ-035 SHALL ignore, and never queue, requests made while busy_o=1; the requester holds its request until req_ready_o=1.
REQ-036 SHALL drive csr_we_o=0 and redirect_valid_o=0 when idle with no inst request; all data outputs SHALL be 0 whenever their valid/enable is 0.

Reset
REQ-037 SHALL, with rst_ni=0, immediately force IDLE, clear the captured pc and cause, and drive busy_o=0, csr_we_o=0, redirect_valid_o=0, redirect_pc_o=0, and req_ready_o=1 and inst_csr_ready_o=1 after release.
REQ-038 SHALL, on reset in mid-sequence, abandon the sequence with no further CSR write and no redirect.

Verification
REQ-039 SHALL cover: ecall with pc=0x80000104, cause=11, MSTATUS=0x8, MTVEC=0x80000201 -> writes MEPC=0x80000104, MCAUSE=11, MSTATUS=0x1880 on cycles 1-3; redirect 0x80000200 on cycle 4.
REQ-040 SHALL cover: mret with MSTATUS=0x1880, MEPC=0x80000108 -> MSTATUS=0x1888 on cycle 1; redirect 0x80000108 on cycle 2.
REQ-041 SHALL cover: ecall and mret asserted together -> ecall sequence only; mret produces no effect.
REQ-042 SHALL cover: instruction write MTVEC=0x80000300 in the same cycle as ecall acceptance -> both accepted; the redirect target is 0x80000300.
REQ-043 SHALL cover: inst write held during T_CAUSE -> inst_csr_ready_o=0 until IDLE, then the write is granted.
REQ-044 SHALL cover: rst_ni=0 during T_CAUSE -> asynchronous return to IDLE, no MSTATUS write, no redirect_valid_o.
